// File: rtl/adc_tilt_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | adc_tilt_pkg : shared encodings and defaults for the ADC tilt filter  |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package adc_tilt_pkg;

  typedef enum logic [1:0] {
    ST_CENTRE = 2'b00,
    ST_LEFT   = 2'b01,
    ST_RIGHT  = 2'b10
  } tilt_state_e;

  localparam logic [1:0]  C_DIR_CENTRE   = 2'b00;
  localparam logic [1:0]  C_DIR_LEFT     = 2'b01;
  localparam logic [1:0]  C_DIR_RIGHT    = 2'b10;

  localparam logic [11:0] C_DEF_CENTRE   = 12'd2048;
  localparam logic [11:0] C_DEF_DEADBAND = 12'd64;
  localparam logic [11:0] C_DEF_HYST     = 12'd16;

  localparam logic [7:0]  C_LED_CENTRE   = 8'b0001_1000;

  // k in 1..8 lit segments; RIGHT grows up from LED[0], LEFT down from LED[7].
  function automatic logic [7:0] bar_mask(input logic [3:0] k, input logic from_msb);
    logic [3:0] sh;
    sh = 4'd8 - k;
    return from_msb ? (8'hFF << sh) : (8'hFF >> sh);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_block_avg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | adc_block_avg : accumulates 2^AVG_LOG2 samples and emits their mean   |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module adc_block_avg #(
  parameter int AVG_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sample,
  input  logic        sample_valid,
  output logic        blk_done,
  output logic [11:0] blk_avg,
  output logic [11:0] avg,
  output logic        avg_valid
);

  localparam int                  ACC_W     = 12 + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] C_CNT_ONE = 1;

  logic [ACC_W-1:0]    acc_q, acc_d, sum;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic [11:0]         avg_q, avg_d;
  logic                valid_q, valid_d;

  // The closing sample is folded into the sum so the next block starts clean.
  always_comb begin
    sum      = acc_q + {{AVG_LOG2{1'b0}}, sample};
    blk_done = sample_valid && (cnt_q == {AVG_LOG2{1'b1}});
    blk_avg  = sum[ACC_W-1:AVG_LOG2];
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    avg_d    = avg_q;
    valid_d  = 1'b0;
    if (sample_valid) begin
      if (blk_done) begin
        acc_d   = '0;
        cnt_d   = '0;
        avg_d   = blk_avg;
        valid_d = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + C_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      avg_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
      valid_q <= valid_d;
    end
  end

  assign avg       = avg_q;
  assign avg_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/adc_tilt_filter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | adc_tilt_filter : averaged, hysteretic tilt classifier + LED bar      |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module adc_tilt_filter
  import adc_tilt_pkg::*;
#(
  parameter int          AVG_LOG2 = 4,
  parameter logic [11:0] CENTRE   = C_DEF_CENTRE,
  parameter logic [11:0] DEADBAND = C_DEF_DEADBAND,
  parameter logic [11:0] HYST     = C_DEF_HYST
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [11:0] SAMPLE,
  input  logic        SAMPLE_VALID,
  output logic [11:0] AVG,
  output logic        AVG_VALID,
  output logic [11:0] DEV,
  output logic [1:0]  DIR,
  output logic [7:0]  LED
);

  logic        blk_done;
  logic [11:0] blk_avg;

  adc_block_avg #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk          (CLOCK_50),
    .rst_n        (RESET_N),
    .sample       (SAMPLE),
    .sample_valid (SAMPLE_VALID),
    .blk_done     (blk_done),
    .blk_avg      (blk_avg),
    .avg          (AVG),
    .avg_valid    (AVG_VALID)
  );

  tilt_state_e        state_q, state_d;
  logic [11:0]        dev_q, dev_d;
  logic [7:0]         led_q, led_d;
  logic signed [12:0] diff, enter_pos, enter_neg, leave_pos, leave_neg;
  logic [11:0]        dev_new;
  logic [3:0]         k;

  // Everything is evaluated on the fresh average so all outputs move on one edge.
  always_comb begin
    diff      = $signed({1'b0, blk_avg}) - $signed({1'b0, CENTRE});
    enter_pos = $signed({1'b0, DEADBAND});
    enter_neg = -enter_pos;
    leave_pos = $signed({1'b0, DEADBAND - HYST});
    leave_neg = -leave_pos;
    dev_new   = diff[12] ? 12'(-diff) : 12'(diff);
    k         = (dev_new[11:8] >= 4'd7) ? 4'd8 : dev_new[11:8] + 4'd1;

    state_d = state_q;
    dev_d   = dev_q;
    led_d   = led_q;
    if (blk_done) begin
      dev_d = dev_new;
      case (state_q)
        ST_RIGHT: begin
          if (diff < enter_neg)       state_d = ST_LEFT;
          else if (diff <= leave_pos) state_d = ST_CENTRE;
        end
        ST_LEFT: begin
          if (diff > enter_pos)       state_d = ST_RIGHT;
          else if (diff >= leave_neg) state_d = ST_CENTRE;
        end
        default: begin
          if (diff > enter_pos)       state_d = ST_RIGHT;
          else if (diff < enter_neg)  state_d = ST_LEFT;
          else                        state_d = ST_CENTRE;
        end
      endcase
      case (state_d)
        ST_RIGHT: led_d = bar_mask(k, 1'b0);
        ST_LEFT:  led_d = bar_mask(k, 1'b1);
        default:  led_d = C_LED_CENTRE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_CENTRE;
      dev_q   <= '0;
      led_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      dev_q   <= dev_d;
      led_q   <= led_d;
    end
  end

  assign DEV = dev_q;
  assign DIR = state_q;
  assign LED = led_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_tilt_filter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_adc_tilt_filter : directed vector bench for adc_tilt_filter        |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_adc_tilt_filter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic [11:0] avg;
  logic        avg_valid;
  logic [11:0] dev;
  logic [1:0]  dir;
  logic [7:0]  led;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  adc_tilt_filter dut (
    .CLOCK_50     (clk),
    .RESET_N      (rst_n),
    .SAMPLE       (sample),
    .SAMPLE_VALID (sample_valid),
    .AVG          (avg),
    .AVG_VALID    (avg_valid),
    .DEV          (dev),
    .DIR          (dir),
    .LED          (led)
  );

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] e_avg;
    logic [11:0] e_dev;
    logic [1:0]  e_dir;
    logic [7:0]  e_led;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Feeds 8x a then 8x b, gap idle cycles (with junk on SAMPLE) between strobes.
  task automatic run_block(input logic [11:0] a, input logic [11:0] b, input int gap);
    int early;
    early = 0;
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (avg_valid) early++;
        sample       = 12'($urandom);
        sample_valid = 1'b0;
      end
      @(negedge clk);
      if (avg_valid) early++;
      sample       = (i < 8) ? a : b;
      sample_valid = 1'b1;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    sample       = 12'($urandom);
    chk("no_early_pulse", early, 0);
    chk("avg_valid_pulse", {31'd0, avg_valid}, 1);
  endtask

  task automatic check_out(input string tag, input logic [11:0] e_avg, input logic [11:0] e_dev,
                           input logic [1:0] e_dir, input logic [7:0] e_led);
    chk({tag, "_avg"}, {20'd0, avg}, {20'd0, e_avg});
    chk({tag, "_dev"}, {20'd0, dev}, {20'd0, e_dev});
    chk({tag, "_dir"}, {30'd0, dir}, {30'd0, e_dir});
    chk({tag, "_led"}, {24'd0, led}, {24'd0, e_led});
    @(negedge clk);
    chk({tag, "_pulse_width"}, {31'd0, avg_valid}, 0);
    chk({tag, "_hold_avg"}, {20'd0, avg}, {20'd0, e_avg});
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{12'd2048, 12'd2048, 12'd2048, 12'd0,    2'b00, 8'h18};
    tbl[1] = '{12'd2200, 12'd2200, 12'd2200, 12'd152,  2'b10, 8'h01};
    tbl[2] = '{12'd2100, 12'd2100, 12'd2100, 12'd52,   2'b10, 8'h01};
    tbl[3] = '{12'd2090, 12'd2090, 12'd2090, 12'd42,   2'b00, 8'h18};
    tbl[4] = '{12'd4095, 12'd4095, 12'd4095, 12'd2047, 2'b10, 8'hFF};
    tbl[5] = '{12'd0,    12'd0,    12'd0,    12'd2048, 2'b01, 8'hFF};
    tbl[6] = '{12'd1748, 12'd1748, 12'd1748, 12'd300,  2'b01, 8'hC0};
    tbl[7] = '{12'd0,    12'd4095, 12'd2047, 12'd1,    2'b00, 8'h18};

    repeat (3) @(negedge clk);
    chk("rst_avg", {20'd0, avg}, 0);
    chk("rst_valid", {31'd0, avg_valid}, 0);
    chk("rst_dir", {30'd0, dir}, 0);
    chk("rst_led", {24'd0, led}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_led", {24'd0, led}, 0);

    for (int r = 0; r < 8; r++) begin
      run_block(tbl[r].a, tbl[r].b, 0);
      check_out($sformatf("vec%0d", r), tbl[r].e_avg, tbl[r].e_dev, tbl[r].e_dir, tbl[r].e_led);
    end

    // Partial block, then reset mid-block: the 10 samples must be discarded.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sample       = 12'd3000;
      sample_valid = 1'b1;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_avg", {20'd0, avg}, 0);
    chk("midrst_dev", {20'd0, dev}, 0);
    chk("midrst_dir", {30'd0, dir}, 0);
    chk("midrst_led", {24'd0, led}, 0);
    rst_n = 1'b1;
    run_block(12'd1000, 12'd1000, 0);
    check_out("after_rst", 12'd1000, 12'd1048, 2'b01, 8'hF8);

    // Sparse strobes: one valid every 7th cycle, junk in between.
    run_block(12'd2200, 12'd2200, 6);
    check_out("sparse_right", 12'd2200, 12'd152, 2'b10, 8'h01);
    run_block(12'd2090, 12'd2090, 6);
    check_out("sparse_centre", 12'd2090, 12'd42, 2'b00, 8'h18);
    run_block(12'd0, 12'd4095, 6);
    check_out("sparse_trunc", 12'd2047, 12'd1, 2'b00, 8'h18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
